// File: rtl/ahb_req_arbiter_if.sv
// Requester-side and AHB-Lite master-side signals of the request arbiter.
// "master" is the arbiter's view; "slave" is the requesters-plus-bus view.
interface ahb_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_write;
  logic [3*NUM_REQ-1:0]  req_size;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;

  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  req, req_write, req_size, req_addr, req_wdata,
    input  HRDATA, HREADY, HRESP,
    output gnt, done, rsp_err, rsp_rdata,
    output HADDR, HWRITE, HSIZE, HBURST, HPROT,
    output HTRANS, HMASTLOCK, HWDATA
  );

  modport slave (
    output req, req_write, req_size, req_addr, req_wdata,
    output HRDATA, HREADY, HRESP,
    input  gnt, done, rsp_err, rsp_rdata,
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT,
    input  HTRANS, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite master port among NUM_REQ
// requesters, one single transfer outstanding at a time.
module ahb_req_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_req_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, ERR
  } state_t;

  state_t state;

  logic [IW-1:0]      last_gnt;
  logic [IW-1:0]      owner;
  logic               mis;
  logic [31:0]        haddr;
  logic               hwrite;
  logic [2:0]         hsize;
  logic [1:0]         htrans;
  logic [31:0]        hwdata;
  logic [NUM_REQ-1:0] done_q;
  logic               err_q;
  logic [31:0]        rdata_q;

  logic               found;
  logic [IW-1:0]      win;
  int                 k;
  logic               w_write;
  logic [2:0]         w_size;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic               w_mis;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] one;

  assign one = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // search starts one past the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(last_gnt) + 1 + i) % NUM_REQ;
      if (!found && bus.req[k]) begin
        found = 1'b1;
        win   = IW'(k);
      end
    end
  end

  always_comb begin
    w_write = bus.req_write[win];
    w_size  = bus.req_size[3*int'(win) +: 3];
    w_addr  = bus.req_addr[32*int'(win) +: 32];
    w_wdata = bus.req_wdata[32*int'(win) +: 32];
    w_mis   = (w_size == 3'd1 && w_addr[0])
           || (w_size == 3'd2 && w_addr[1:0] != 2'b00)
           || (w_size > 3'd2);
    gnt     = (state == IDLE && found) ? (one << win) : '0;
    own_oh  = one << owner;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= IDLE;
      last_gnt <= IW'(NUM_REQ - 1);
      owner    <= '0;
      mis      <= 1'b0;
      haddr    <= '0;
      hwrite   <= 1'b0;
      hsize    <= '0;
      htrans   <= 2'b00;
      hwdata   <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      done_q <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            last_gnt <= win;
            owner    <= win;
            mis      <= w_mis;
            if (w_mis) begin
              state <= ERR;
            end else begin
              state  <= ADDR;
              htrans <= 2'b10;
              haddr  <= w_addr;
              hwrite <= w_write;
              hsize  <= w_size;
              hwdata <= w_wdata;
            end
          end
        end
        ADDR: begin
          if (bus.HREADY) begin
            state  <= DATA;
            htrans <= 2'b00;
          end
        end
        DATA: begin
          if (bus.HRESP && !bus.HREADY) begin
            state <= ERR;
          end else if (bus.HREADY) begin
            state  <= IDLE;
            done_q <= own_oh;
            err_q  <= bus.HRESP;
            if (!bus.HRESP && !hwrite) rdata_q <= bus.HRDATA;
          end
        end
        ERR: begin
          // alignment faults never reached the bus, so no HREADY to wait on
          if (mis || bus.HREADY) begin
            state  <= IDLE;
            done_q <= own_oh;
            err_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.done      = done_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.HADDR     = haddr;
  assign bus.HWRITE    = hwrite;
  assign bus.HSIZE     = hsize;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HTRANS    = htrans;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = hwdata;
endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter: per-cycle bus checks plus a
// scoreboard of expected completions popped on every done pulse.
module tb_ahb_req_arbiter;
  localparam int N = 4;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb_req_arbiter_if #(.NUM_REQ(N)) bus ();

  ahb_req_arbiter #(.NUM_REQ(N)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    bit          err;
    bit          rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rd = '0;

  function automatic logic [N-1:0] onehot(input int i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rq(input int i, input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    bus.req_write[i]         = wr;
    bus.req_size[3*i +: 3]   = sz;
    bus.req_addr[32*i +: 32] = a;
    bus.req_wdata[32*i +: 32] = wd;
  endtask

  task automatic push(input int i, input bit err, input bit rd,
                      input logic [31:0] rdata);
    exp_t e;
    e.idx   = i;
    e.err   = err;
    e.rd    = rd;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // called right after driving req at a falling edge
  task automatic wait_gnt(input logic [N-1:0] exp, input string tag);
    int n;
    n = 0;
    #1;
    while (bus.gnt === '0 && n < 12) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    chk(tag, bus.gnt, exp);
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge HCLK);
      n++;
    end
    #1;
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  always @(negedge HCLK) begin : mon
    exp_t e;
    if (bus.done !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", bus.done, '0);
      end else begin
        e = sb.pop_front();
        if (e.rd && !e.err) last_rd = e.rdata;
        chk("done_vec", bus.done, onehot(e.idx));
        chk("done_err", bus.rsp_err, e.err);
        chk("rsp_rdata", bus.rsp_rdata, last_rd);
      end
    end
    if (HRESETn === 1'b0) last_rd = '0;
  end

  initial begin
    logic [N-1:0] seq2 [4];
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_size  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.HRDATA    = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;

    repeat (2) @(negedge HCLK);
    #1;
    chk("rst_gnt", bus.gnt, '0);
    chk("rst_done", bus.done, '0);
    chk("rst_err", bus.rsp_err, 1'b0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_htrans", bus.HTRANS, 2'b00);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwrite", bus.HWRITE, 1'b0);
    chk("rst_hsize", bus.HSIZE, 3'b000);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("hburst", bus.HBURST, 3'b000);
    chk("hprot", bus.HPROT, 4'b0011);
    chk("hmastlock", bus.HMASTLOCK, 1'b0);
    HRESETn = 1'b1;

    // single write, zero wait states
    @(negedge HCLK);
    set_rq(0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    bus.req = 4'b0001;
    #1;
    chk("w_gnt_c0", bus.gnt, 4'b0001);
    push(0, 1'b0, 1'b0, 32'h0);
    @(negedge HCLK);
    bus.req = '0;
    #1;
    chk("w_htrans_c1", bus.HTRANS, 2'b10);
    chk("w_haddr_c1", bus.HADDR, 32'h100);
    chk("w_hwrite_c1", bus.HWRITE, 1'b1);
    chk("w_hsize_c1", bus.HSIZE, 3'd2);
    chk("w_gnt_c1", bus.gnt, '0);
    @(negedge HCLK);
    #1;
    chk("w_htrans_c2", bus.HTRANS, 2'b00);
    chk("w_hwdata_c2", bus.HWDATA, 32'hDEADBEEF);
    @(negedge HCLK);
    #1;
    chk("w_done_c3", bus.done, 4'b0001);
    chk("w_err_c3", bus.rsp_err, 1'b0);
    drain(4, "w_drain");

    // round robin with all four requesting, then 0 and 3 only
    do_reset();
    for (int i = 0; i < N; i++) set_rq(i, 1'b0, 3'd2, 32'h200 + 4*i, 32'h0);
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(onehot(i), "rr_all");
      bus.HRDATA = 32'hA5A5_0000 + i;
      push(i, 1'b0, 1'b1, 32'hA5A5_0000 + i);
      @(negedge HCLK);
    end
    bus.req = 4'b1001;
    seq2[0] = 4'b0001;
    seq2[1] = 4'b1000;
    seq2[2] = 4'b0001;
    seq2[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(seq2[i], "rr_1001");
      bus.HRDATA = 32'h5A5A_0000 + i;
      push((seq2[i] == 4'b0001) ? 0 : 3, 1'b0, 1'b1, 32'h5A5A_0000 + i);
      @(negedge HCLK);
    end
    bus.req = '0;
    drain(12, "rr_drain");

    // read with wait states in both phases
    @(negedge HCLK);
    set_rq(1, 1'b0, 3'd2, 32'h40, 32'h0);
    bus.HREADY = 1'b0;
    bus.HRDATA = 32'hBAD0BAD0;
    bus.req = 4'b0010;
    wait_gnt(4'b0010, "ws_gnt");
    push(1, 1'b0, 1'b1, 32'h12345678);
    for (int c = 1; c <= 3; c++) begin
      @(negedge HCLK);
      bus.req = '0;
      if (c == 3) bus.HREADY = 1'b1;
      #1;
      chk("ws_addr_htrans", bus.HTRANS, 2'b10);
      chk("ws_addr_haddr", bus.HADDR, 32'h40);
    end
    for (int c = 4; c <= 7; c++) begin
      @(negedge HCLK);
      bus.HREADY = (c == 7);
      if (c == 7) bus.HRDATA = 32'h12345678;
      #1;
      chk("ws_data_htrans", bus.HTRANS, 2'b00);
      chk("ws_data_haddr", bus.HADDR, 32'h40);
      chk("ws_data_done", bus.done, '0);
    end
    @(negedge HCLK);
    #1;
    chk("ws_done", bus.done, 4'b0010);
    chk("ws_rdata", bus.rsp_rdata, 32'h12345678);
    drain(4, "ws_drain");

    // two-cycle error response on a write
    @(negedge HCLK);
    set_rq(2, 1'b1, 3'd2, 32'h80, 32'h11112222);
    bus.req = 4'b0100;
    wait_gnt(4'b0100, "er_gnt");
    push(2, 1'b1, 1'b0, 32'h0);
    @(negedge HCLK);
    bus.req = '0;
    #1;
    chk("er_htrans_c1", bus.HTRANS, 2'b10);
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    bus.HRESP = 1'b1;
    #1;
    chk("er_htrans_c2", bus.HTRANS, 2'b00);
    chk("er_hwdata_c2", bus.HWDATA, 32'h11112222);
    @(negedge HCLK);
    bus.HREADY = 1'b1;
    #1;
    chk("er_htrans_c3", bus.HTRANS, 2'b00);
    chk("er_done_c3", bus.done, '0);
    @(negedge HCLK);
    bus.HRESP = 1'b0;
    #1;
    chk("er_done_c4", bus.done, 4'b0100);
    chk("er_err_c4", bus.rsp_err, 1'b1);
    chk("er_htrans_c4", bus.HTRANS, 2'b00);
    @(negedge HCLK);
    #1;
    chk("er_htrans_c5", bus.HTRANS, 2'b00);
    drain(4, "er_drain");

    // misaligned word, illegal size, misaligned halfword
    @(negedge HCLK);
    set_rq(3, 1'b1, 3'd2, 32'h102, 32'h0);
    bus.req = 4'b1000;
    wait_gnt(4'b1000, "mis_gnt");
    push(3, 1'b1, 1'b0, 32'h0);
    @(negedge HCLK);
    bus.req = '0;
    #1;
    chk("mis_htrans_c1", bus.HTRANS, 2'b00);
    chk("mis_haddr_c1", bus.HADDR, 32'h80);
    chk("mis_done_c1", bus.done, '0);
    @(negedge HCLK);
    #1;
    chk("mis_done_c2", bus.done, 4'b1000);
    chk("mis_err_c2", bus.rsp_err, 1'b1);
    chk("mis_htrans_c2", bus.HTRANS, 2'b00);
    drain(4, "mis_drain");

    @(negedge HCLK);
    set_rq(0, 1'b0, 3'd3, 32'h0, 32'h0);
    bus.req = 4'b0001;
    wait_gnt(4'b0001, "ill_gnt");
    push(0, 1'b1, 1'b1, 32'h0);
    @(negedge HCLK);
    bus.req = '0;
    #1;
    chk("ill_htrans", bus.HTRANS, 2'b00);
    drain(4, "ill_drain");

    @(negedge HCLK);
    set_rq(1, 1'b0, 3'd1, 32'h41, 32'h0);
    bus.req = 4'b0010;
    wait_gnt(4'b0010, "hw_gnt");
    push(1, 1'b1, 1'b1, 32'h0);
    @(negedge HCLK);
    bus.req = '0;
    #1;
    chk("hw_htrans", bus.HTRANS, 2'b00);
    drain(4, "hw_drain");

    // reset while in the data phase
    @(negedge HCLK);
    set_rq(2, 1'b1, 3'd2, 32'h300, 32'h55);
    bus.req = 4'b0100;
    wait_gnt(4'b0100, "rm_gnt");
    @(negedge HCLK);
    bus.req = '0;
    #1;
    chk("rm_htrans_c1", bus.HTRANS, 2'b10);
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk("rm_htrans_c2", bus.HTRANS, 2'b00);
    @(negedge HCLK);
    #1;
    chk("rm_htrans_c3", bus.HTRANS, 2'b00);
    chk("rm_done_c3", bus.done, '0);
    chk("rm_haddr_c3", bus.HADDR, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus.HREADY = 1'b1;
    #1;
    chk("rm_done_c4", bus.done, '0);
    @(negedge HCLK);
    for (int i = 0; i < N; i++) set_rq(i, 1'b0, 3'd2, 32'h400 + 4*i, 32'h0);
    bus.HRDATA = 32'h77;
    bus.req = 4'b1111;
    wait_gnt(4'b0001, "rm_next_gnt");
    push(0, 1'b0, 1'b1, 32'h77);
    @(negedge HCLK);
    bus.req = '0;
    drain(6, "rm_drain");

    repeat (3) @(negedge HCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahb_req_arbiter.md
AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be HCLK and HRESETn.
REQ-003 HCLK  in  1  clock; all state SHALL update on its rising edge.
REQ-004 HRESETn  in  1  reset, synchronous, active-low.
REQ-005 req  in  NUM_REQ  per-requester transfer request, level.
REQ-006 req_write  in  NUM_REQ  per-requester direction: 1 = write.
REQ-007 req_size  in  3*NUM_REQ  per-requester HSIZE encoding.
REQ-008 req_addr  in  32*NUM_REQ  per-requester byte address.
REQ-009 req_wdata  in  32*NUM_REQ  per-requester write data.
REQ-010 gnt  out  NUM_REQ  one-hot accept pulse.
REQ-011 done  out  NUM_REQ  one-hot completion pulse.
REQ-012 rsp_err  out  1  error flag; valid with done.
REQ-013 rsp_rdata  out  32  read data; valid with done for reads.
REQ-014 HADDR  out  32; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HTRANS  out  2; HMASTLOCK  out  1; HWDATA  out  32  AHB-Lite master outputs.
REQ-015 HRDATA  in  32; HREADY  in  1; HRESP  in  1  AHB-Lite master inputs.

Function
REQ-016 The block SHALL share one AHB-Lite master port among NUM_REQ requesters, with at most one transfer outstanding.
REQ-017 The FSM SHALL have states IDLE, ADDR, DATA and ERR.
REQ-018 HBURST SHALL be 3'b000 (SINGLE), HPROT 4'b0011 and HMASTLOCK 0 at all times.
REQ-019 In IDLE with any req bit set, gnt SHALL assert combinationally for exactly one requester, chosen round-robin starting at (last_granted+1) mod NUM_REQ.
REQ-020 In that cycle the block SHALL register the winner's index, write, size, addr and wdata, update last_granted, and move to ADDR.
REQ-021 A requester MAY drop req after its gnt cycle; the registered fields SHALL NOT change until the next grant.
REQ-022 gnt SHALL be zero outside IDLE and in IDLE when req is zero.
REQ-023 A request SHALL be misaligned when size=1 and addr[0]=1, or size=2 and addr[1:0]!=0; size>2 SHALL also be illegal.
REQ-024 A misaligned or illegal request SHALL go IDLE->ERR, with no bus activity (HTRANS=IDLE).
REQ-025 In ADDR, HTRANS SHALL be 2'b10 (NONSEQ) and HADDR/HWRITE/HSIZE SHALL come from the registered fields; while HREADY=0 the block SHALL hold these, and on HREADY=1 it SHALL move to DATA.
REQ-026 In DATA, HTRANS SHALL be IDLE and HWDATA SHALL hold the registered wdata.
REQ-027 In DATA, HREADY=1 with HRESP=0 SHALL cause a done pulse for the owner with rsp_err=0, capture rsp_rdata from HRDATA on reads, and return to IDLE.
REQ-028 In DATA, HRESP=1 with HREADY=0 (first error cycle) SHALL move to ERR.
REQ-029 In ERR, the block SHALL wait for HREADY=1, then pulse done for the owner with rsp_err=1 and return to IDLE; a misaligned request SHALL complete from ERR on the next cycle regardless of HREADY.
REQ-030 rsp_rdata SHALL hold its value until the next read completes.
REQ-031 done SHALL be a registered pulse asserted the cycle after completion is detected, lasting exactly one cycle.
REQ-032 Latency SHALL be as follows: with zero wait states, gnt in cycle 0, ADDR in cycle 1, DATA in cycle 2 and done in cycle 3; the next grant SHALL be possible in cycle 3 (IDLE).
REQ-033 Outside ADDR, HADDR/HWRITE/HSIZE SHALL keep their last values and HTRANS SHALL be IDLE.

Reset
REQ-034 HRESETn=0 at a rising edge SHALL force state IDLE, last_granted=NUM_REQ-1 (requester 0 first), gnt=0, done=0, rsp_err=0, rsp_rdata=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=0 and HWDATA=0.
REQ-035 Reset during ADDR, DATA or ERR SHALL abandon the transfer with no done pulse; HTRANS SHALL be IDLE in the cycle after reset is sampled.

Verification
REQ-036 Single write: req[0] with addr 0x100, wdata 0xDEADBEEF, size 2, HREADY=1 -> gnt[0] in cycle 0; NONSEQ with HADDR 0x100 in cycle 1; HWDATA 0xDEADBEEF in cycle 2; done[0]=1 and rsp_err=0 in cycle 3.
REQ-037 Round-robin: req=4'b1111 held for 4 transfers after reset -> grant order 0,1,2,3; then req=4'b1001 -> 0,3,0,3.
REQ-038 Wait states: read of 0x40 with HREADY low for 2 cycles in ADDR and 3 cycles in DATA, HRDATA 0x12345678 -> HADDR stable throughout; done with rsp_rdata 0x12345678 only after HREADY=1.
REQ-039 Error response: HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1 -> state ERR, then done with rsp_err=1 and no second NONSEQ.
REQ-040 Misaligned: size 2 at addr 0x102 -> HTRANS stays IDLE; done with rsp_err=1 two cycles after gnt.
REQ-041 Reset mid-transfer: HRESETn low in DATA -> no done pulse, HTRANS IDLE; the next grant goes to requester 0.
